// File: rtl/rr_arbiter4_if.sv
// rtl/rr_arbiter4_if.sv - request/grant bundle between four requesters and rr_arbiter4.
// The expired pulse exists only when ARB_TIMEOUT_EN is defined.
interface rr_arbiter4_if;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       busy;
  logic       dout;
`ifdef ARB_TIMEOUT_EN
  logic       expired;
`endif

  modport master (
    output req,
    output din,
    input  gnt,
    input  sel,
    input  busy,
`ifdef ARB_TIMEOUT_EN
    input  expired,
`endif
    input  dout
  );

  modport slave (
    input  req,
    input  din,
    output gnt,
    output sel,
    output busy,
`ifdef ARB_TIMEOUT_EN
    output expired,
`endif
    output dout
  );
endinterface

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - 4-way round-robin arbiter with registered 4:1 data mux.
// Optional hold-time limit compiled in with ARB_TIMEOUT_EN.
module rr_arbiter4 #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  rr_arbiter4_if.slave bus
);

  if (HOLD_MAX < 1 || HOLD_MAX > 15) begin : g_bad_hold_max
    $error("rr_arbiter4: HOLD_MAX must be in 1..15");
  end

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] last_q, last_d;
  logic [3:0] gnt_q, gnt_d;
  logic       dout_q, dout_d;
  // Blocks arbitration on the first edge after reset release.
  logic       ready_q, ready_d;
`ifdef ARB_TIMEOUT_EN
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);
  logic [3:0] cnt_q, cnt_d;
  logic       expired_q, expired_d;
`endif

  logic       found;
  logic [1:0] win;
  logic [1:0] idx;

  // Search last_owner+1 .. last_owner; the previous owner is checked last.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    idx   = last_q;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    ready_d   = 1'b1;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    expired_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (ready_q && found) begin
          state_d = S_GRANT;
          sel_d   = win;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = 4'd0;
`endif
        end
      end
      S_GRANT: begin
        if (!bus.req[sel_q]) begin
          state_d = S_IDLE;
          last_d  = sel_q;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == HOLD_LAST) begin
          state_d   = S_IDLE;
          last_d    = sel_q;
          expired_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
    gnt_d  = (state_d == S_GRANT) ? (4'b0001 << sel_d) : 4'b0000;
    dout_d = (state_d == S_GRANT) & bus.din[sel_d];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sel_q     <= 2'd0;
      last_q    <= 2'd3;
      gnt_q     <= 4'b0000;
      dout_q    <= 1'b0;
      ready_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= 4'd0;
      expired_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      dout_q    <= dout_d;
      ready_q   <= ready_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
`endif
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.sel  = sel_q;
  assign bus.busy = (state_q == S_GRANT);
  assign bus.dout = dout_q;
`ifdef ARB_TIMEOUT_EN
  assign bus.expired = expired_q;
`endif

endmodule
